mips_mdu: RTL and testbench
===========================

Name: mips_mdu

Overview:
Parametrised iterative multiply/divide unit for the multi-cycle MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles and holds the result in architectural HI/LO registers. The controller reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO. It sits beside the ALU in the datapath; the controller stalls on busy and advances on done.

Parameters:
WIDTH, 32, operand width and HI/LO register width; any value >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
flush  input  1  abort in-flight operation
wr_hi  input  1  MTHI write strobe
wr_lo  input  1  MTLO write strobe
wr_data  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse; HI/LO updated
dbz  output  1  divide-by-zero flag; valid with done
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0 at edge): state=IDLE; hi=0, lo=0, busy=0, done=0, dbz=0, counter=0. Overrides all other inputs, including mid-operation.
- States: IDLE, CALC, FIX.
  - IDLE: start=1 latches op, |a|, |b| (magnitudes for signed ops, raw values for unsigned) and the sign flags; counter=WIDTH; go to CALC.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements; when counter reaches 1, go to FIX.
  - FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Latency: start sampled at edge k. busy=1 after edges k+1 through k+WIDTH. After edge k+WIDTH+1: busy=0, done=1, hi/lo hold the result. done falls after edge k+WIDTH+2 unless a new result completes.
- Multiply: {hi,lo} = 2*WIDTH-bit product. Signed result is negated when sign(a)^sign(b).
- Divide: lo=quotient, hi=remainder, truncation toward zero. Remainder takes the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): full latency still applies. hi=a (raw), lo={WIDTH{1'b1}}, dbz=1 with done. dbz=0 with done for every other result.
- Signed overflow (a=MIN, b=-1, DIV): lo=MIN, hi=0, dbz=0.
- start while busy or in FIX: ignored; no queuing.
- flush=1 in CALC or FIX: next state IDLE; hi/lo unchanged; no done pulse. flush in IDLE: no effect. If start and flush are both 1 in IDLE, flush has no effect and start is accepted.
- wr_hi/wr_lo: hi/lo = wr_data at the edge, only in IDLE with start=0. Ignored otherwise, without error. wr_hi and wr_lo may both be set together.
- The completion write in FIX overrides any concurrent wr_hi/wr_lo.
- hi/lo are registered outputs; they are stable between writes.

Test Plan:
- WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> after 33 cycles: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy deasserted the same cycle.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; then MULT with the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0, dbz=0.
- DIVU a=100, b=0 -> done after 33 cycles: dbz=1, hi=0x00000064, lo=0xFFFFFFFF. Next DIVU 100/7 -> lo=14, hi=2, dbz=0.
- Start MULTU 5*5, flush at cycle 10 -> no done pulse, hi/lo retain prior values; start pulsed at cycle 15 is ignored while busy; wr_lo=1 in IDLE with wr_data=0x1234 -> lo=0x1234.
- reset=0 mid-DIV (cycle 20) -> next cycle busy=0, done=0, hi=lo=0. Repeat with WIDTH=8: MULT -128*-128 -> hi=0x40, lo=0x00 after 9 cycles.

Source files
------------

// File: rtl/mips_mdu.sv
// mips_mdu: iterative multiply/divide unit with architectural HI/LO.
// Runs MULT/MULTU/DIV/DIVU on operand magnitudes. Each multiply step is a
// shift-add and each divide step is a restoring subtract. Signs are fixed
// up in a final FIX cycle.
// Ports:
//   clk, reset (sync, active low)
//   start/op/a/b : launch an operation (sampled only in IDLE)
//   flush        : abort an in-flight operation
//   wr_hi/wr_lo/wr_data : MTHI/MTLO writes (IDLE, no start)
//   busy, done (1-cycle pulse), dbz (with done), hi, lo
module mips_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Shared datapath register.
  // Multiply: {upper[W:0], multiplier/low product[W-1:0]}.
  // Divide:   {remainder[W:0], dividend/quotient[W-1:0]}.
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;       // |b|: multiplicand or divisor
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // raw dividend, returned on divide-by-zero
  logic               is_div_q, is_div_d;
  logic               sgn_a_q, sgn_a_d;
  logic               sgn_b_q, sgn_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes at launch
  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Iteration steps
  logic [WIDTH:0]   mul_upper;
  logic [2*WIDTH:0] mul_step;
  logic [WIDTH:0]   rem_sh;
  logic [2*WIDTH:0] div_step;

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, quo_s, rem, rem_s;

  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_upper, acc_q[WIDTH-1:0]} >> 1;

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it does not go negative.
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    if (rem_sh >= {1'b0, opb_q})
      div_step = {rem_sh - {1'b0, opb_q}, acc_q[WIDTH-2:0], 1'b1};
    else
      div_step = {rem_sh, acc_q[WIDTH-2:0], 1'b0};

    prod   = acc_q[2*WIDTH-1:0];
    prod_s = (sgn_a_q ^ sgn_b_q) ? -prod : prod;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    quo_s  = (sgn_a_q ^ sgn_b_q) ? -quo : quo;
    rem_s  = sgn_a_q ? -rem : rem;   // remainder follows the dividend
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = CNT_W'(WIDTH);
          acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
          opb_d    = mag_b;
          a_raw_d  = a;
          is_div_d = op[1];
          sgn_a_d  = signed_op & a[WIDTH-1];
          sgn_b_d  = signed_op & b[WIDTH-1];
          busy_d   = 1'b1;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_s;
          end else if (opb_q == '0) begin
            hi_d  = a_raw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: scoreboard bench for mips_mdu at WIDTH=32 and WIDTH=8.
// Expected results come from a plain-arithmetic model. They are queued when an
// operation is issued and popped by per-DUT monitors on each done pulse.
module tb_mips_mdu;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start, flush, wr_hi, wr_lo, busy, done, dbz;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data, hi, lo;

  logic        start8, flush8, wr_hi8, wr_lo8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wr_data8, hi8, lo8;

  mips_mdu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo));

  mips_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8),
    .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  logic [31:0] mhi[2];   // architectural HI/LO model; index 0 = W32, 1 = W8
  logic [31:0] mlo[2];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS MDU semantics from plain integer arithmetic.
  function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mask, ua, ub, pu;
    longint      sa, sb;
    logic [31:0] rh, rl;
    logic        z;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, x} & mask;
    ub = {32'b0, y} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    z = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin
        pu = 64'(sa * sb);
        rh = 32'((pu >> w) & mask);
        rl = 32'(pu & mask);
      end
      2'b01: begin
        pu = ua * ub;
        rh = 32'((pu >> w) & mask);
        rl = 32'(pu & mask);
      end
      2'b10: begin
        if (sb == 0) begin
          z = 1'b1; rh = 32'(ua); rl = 32'(mask);
        end else begin
          pu = 64'(sa / sb); rl = 32'(pu & mask);
          pu = 64'(sa % sb); rh = 32'(pu & mask);
        end
      end
      default: begin
        if (ub == 0) begin
          z = 1'b1; rh = 32'(ua); rl = 32'(mask);
        end else begin
          pu = ua / ub; rl = 32'(pu & mask);
          pu = ua % ub; rh = 32'(pu & mask);
        end
      end
    endcase
    return {z, rh, rl};
  endfunction

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done32_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e32 = q32.pop_front();
        check("hi32", hi, e32.hi);
        check("lo32", lo, e32.lo);
        check("dbz32", {31'b0, dbz}, {31'b0, e32.dbz});
        check("latency32", 32'(cyc), 32'(e32.cyc));
        check("busy32_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done8_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        check("hi8", {24'b0, hi8}, e8.hi);
        check("lo8", {24'b0, lo8}, e8.lo);
        check("dbz8", {31'b0, dbz8}, {31'b0, e8.dbz});
        check("latency8", 32'(cyc), 32'(e8.cyc));
        check("busy8_at_done", {31'b0, busy8}, 32'd0);
      end
    end
  end

  task automatic set_in(input int w, input logic s, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y, input logic f,
                        input logic wh, input logic wl, input logic [31:0] d);
    if (w == 32) begin
      start = s; op = o; a = x; b = y; flush = f; wr_hi = wh; wr_lo = wl; wr_data = d;
    end else begin
      start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0]; flush8 = f;
      wr_hi8 = wh; wr_lo8 = wl; wr_data8 = d[7:0];
    end
  endtask

  task automatic check_regs(input int w);
    if (w == 32) begin
      check("hi32_reg", hi, mhi[0]);
      check("lo32_reg", lo, mlo[0]);
    end else begin
      check("hi8_reg", {24'b0, hi8}, mhi[1]);
      check("lo8_reg", {24'b0, lo8}, mlo[1]);
    end
  endtask

  // One operation. abort_at = cycle offset of flush (or reset when is_rst),
  // -1 for none; wr_at = offset of an MTHI/MTLO pulse that must be ignored;
  // stray_at = offset of an extra start that must be ignored (0 = none).
  task automatic run_op(input int w, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int abort_at, input bit is_rst,
                        input int wr_at, input int stray_at);
    logic [64:0] r;
    exp_t        e;
    int          idx;
    bit          aborted;
    logic        s, f, wh;
    idx = (w == 8) ? 1 : 0;
    aborted = (abort_at >= 1) && (abort_at <= w + 1);
    r = model(w, o, x, y);
    @(posedge clk); #1;
    for (int c = 0; c <= w + 3; c++) begin
      s  = (c == 0) || (stray_at > 0 && c == stray_at);
      f  = (c == abort_at) && !is_rst;
      wh = (c == wr_at);
      if (c == 0) set_in(w, s, o, x, y, f, wh, wh, 32'hC0DE_F00D);
      else        set_in(w, s, ~o, ~x, y + 32'd1, f, wh, wh, 32'hC0DE_F00D ^ 32'(c));
      if (is_rst && c == abort_at) reset = 1'b0;
      @(posedge clk); #1;
      if (c == 0 && !aborted) begin
        e.hi = r[63:32]; e.lo = r[31:0]; e.dbz = r[64]; e.cyc = cyc + w + 1;
        if (w == 32) q32.push_back(e); else q8.push_back(e);
      end
      if (is_rst && c == abort_at) begin
        reset = 1'b1;
        check("rst_busy", {31'b0, (w == 32) ? busy : busy8}, 32'd0);
        check("rst_done", {31'b0, (w == 32) ? done : done8}, 32'd0);
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
        check_regs(w);
      end
      set_in(w, 1'b0, o, x, y, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    check("pending", 32'((w == 32) ? q32.size() : q8.size()), 32'd0);
    if (!aborted) begin
      mhi[idx] = r[63:32];
      mlo[idx] = r[31:0];
    end else begin
      check_regs(w);
    end
  endtask

  task automatic mt(input int w, input logic wh, input logic wl, input logic [31:0] d);
    int idx;
    logic [31:0] m;
    idx = (w == 8) ? 1 : 0;
    m = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
    @(posedge clk); #1;
    set_in(w, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, wh, wl, d);
    @(posedge clk); #1;
    set_in(w, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    if (wh) mhi[idx] = d & m;
    if (wl) mlo[idx] = d & m;
    check_regs(w);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    logic [31:0] v;
    m = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1 << (w - 1);
      4: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic random_ops(input int w, input int n);
    int mode, ab, wr, st;
    for (int i = 0; i < n; i++) begin
      mode = $urandom_range(0, 9);
      ab = -1; wr = -1; st = 0;
      if (mode == 0) begin
        ab = $urandom_range(1, w + 1);
        wr = $urandom_range(0, ab);
      end else if (mode == 1) begin
        st = $urandom_range(1, w + 1);
      end else if (mode == 2) begin
        wr = $urandom_range(0, w + 1);
      end
      run_op(w, 2'($urandom_range(0, 3)), pick(w), pick(w), ab, 1'b0, wr, st);
      if (mode == 3) mt(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(32, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_in(8, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy32", {31'b0, busy}, 32'd0);
    check("reset_done32", {31'b0, done}, 32'd0);
    check("reset_dbz32", {31'b0, dbz}, 32'd0);
    check("reset_busy8", {31'b0, busy8}, 32'd0);
    check("reset_done8", {31'b0, done8}, 32'd0);
    check_regs(32);
    check_regs(8);
    reset = 1'b1;

    // Directed cases, WIDTH=32
    run_op(32, 2'b00, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, -1, 0);
    run_op(32, 2'b01, 32'hFFFF_FFFF, 32'd2, -1, 1'b0, -1, 0);
    run_op(32, 2'b00, 32'hFFFF_FFFF, 32'd2, -1, 1'b0, -1, 0);
    run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, -1, 0);
    run_op(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, -1, 0);
    run_op(32, 2'b11, 32'd100, 32'd0, -1, 1'b0, -1, 0);
    run_op(32, 2'b10, 32'hFFFF_FF9C, 32'd0, -1, 1'b0, -1, 0);
    run_op(32, 2'b11, 32'd100, 32'd7, -1, 1'b0, -1, 0);
    run_op(32, 2'b01, 32'd5, 32'd5, 10, 1'b0, -1, 0);     // flushed
    run_op(32, 2'b01, 32'd5, 32'd5, -1, 1'b0, -1, 15);    // stray start in CALC
    run_op(32, 2'b01, 32'd6, 32'd6, -1, 1'b0, -1, 33);    // stray start in FIX
    run_op(32, 2'b00, 32'd9, 32'd9, 0, 1'b0, -1, 0);      // flush with start: accepted
    run_op(32, 2'b01, 32'd9, 32'd9, 12, 1'b0, 5, 0);      // MT write while busy, then flush
    run_op(32, 2'b00, 32'd3, 32'd3, -1, 1'b0, 33, 0);     // completion beats MT write
    mt(32, 1'b0, 1'b1, 32'h1234);
    mt(32, 1'b1, 1'b0, 32'hABCD_0001);
    mt(32, 1'b1, 1'b1, 32'h5555_AAAA);
    run_op(32, 2'b10, 32'd1000, 32'd3, 20, 1'b1, -1, 0);  // reset mid-divide

    // Directed cases, WIDTH=8
    run_op(8, 2'b00, 32'h80, 32'h80, -1, 1'b0, -1, 0);
    run_op(8, 2'b10, 32'h80, 32'hFF, -1, 1'b0, -1, 0);
    run_op(8, 2'b11, 32'h64, 32'h00, -1, 1'b0, -1, 0);
    run_op(8, 2'b10, 32'hF9, 32'h02, -1, 1'b0, -1, 0);

    random_ops(32, 30);
    random_ops(8, 30);

    repeat (5) @(posedge clk);
    #1;
    check("final_pending32", 32'(q32.size()), 32'd0);
    check("final_pending8", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
